// File: rtl/core_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
//   word_t       : 32-bit instruction word
//   ptr_t        : 30-bit word address
//   fifo_entry_t : buffered response word together with its word address
//   byte_addr()  : converts a word address to the byte address shown to decode
package core_prefetch_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [29:0] ptr_t;

    typedef struct packed {
        word_t data;
        ptr_t  addr;
    } fifo_entry_t;

    function automatic word_t byte_addr(input ptr_t a);
        return {a, 2'b00};
    endfunction

endpackage

// File: rtl/core_prefetch_fifo.sv
// Small power-of-two FIFO that buffers fetched words ahead of decode.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear_i             : empties the FIFO (wins over push/pop)
//   push_i, push_data_i : write one entry
//   pop_i               : drop the head entry (caller guarantees non-empty)
//   count_o, empty_o    : occupancy
//   head_o              : head entry, valid when !empty_o
// Push and pop in the same cycle are allowed even when full: the head is read
// before the edge that overwrites its slot.
module core_prefetch_fifo
    import core_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fifo_entry_t                push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output fifo_entry_t                head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t    mem_q [DEPTH];
    logic [AW-1:0]  rd_q;
    logic [AW-1:0]  wr_q;
    logic [CW-1:0]  count_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= {AW{1'b0}};
            wr_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else if (clear_i) begin
            rd_q    <= {AW{1'b0}};
            wr_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            rd_q    <= pop_i  ? rd_q + {{(AW-1){1'b0}}, 1'b1} : rd_q;
            wr_q    <= push_i ? wr_q + {{(AW-1){1'b0}}, 1'b1} : wr_q;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == {CW{1'b0}});
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/core_prefetch_queue.sv
// Instruction prefetch stage: issues sequential word reads, buffers returned
// words and hands one instruction per cycle to decode.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : decode cannot accept, output registers hold
//   flush, target         : redirect fetch to word address target (pulse)
//   bus_start, bus_addr   : registered read request pulse and word address
//   bus_ready, bus_data   : response strobe and data
//   insn, insn_pc         : instruction and its byte address
//   insn_nop              : 1 = bubble this cycle
module core_prefetch_queue
    import core_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] target,
    output logic        bus_start,
    output logic [29:0] bus_addr,
    input  logic        bus_ready,
    input  logic [31:0] bus_data,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_nop
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ptr_t   fetch_pc_q, fetch_pc_d;
    logic   outstanding_q, outstanding_d;
    logic   discard_q, discard_d;
    logic   bus_start_q;
    ptr_t   bus_addr_q, bus_addr_d;
    word_t  insn_q, insn_d;
    word_t  insn_pc_q, insn_pc_d;
    logic   insn_nop_q, insn_nop_d;

    logic          fifo_clear_s, fifo_push_s, fifo_pop_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s, count_next_s;
    fifo_entry_t   fifo_head_s;

    logic resp_s;       // response that closes the outstanding request
    logic resp_keep_s;  // response whose word is delivered
    logic issue_s;
    ptr_t issue_addr_s;

    // bus_addr_q still holds the address of the single outstanding request.
    assign resp_s      = bus_ready && outstanding_q;
    assign resp_keep_s = resp_s && !discard_q && !flush;

    core_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (fifo_clear_s),
        .push_i      (fifo_push_s),
        .push_data_i ({bus_data, bus_addr_q}),
        .pop_i       (fifo_pop_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .head_o      (fifo_head_s)
    );

    // Output path: flush bubbles, otherwise pop the head or bypass the response.
    always_comb begin
        fifo_clear_s = 1'b0;
        fifo_push_s  = 1'b0;
        fifo_pop_s   = 1'b0;
        insn_d       = insn_q;
        insn_pc_d    = insn_pc_q;
        insn_nop_d   = insn_nop_q;
        if (flush) begin
            fifo_clear_s = 1'b1;
            insn_nop_d   = 1'b1;
        end else if (!stall) begin
            if (!fifo_empty_s) begin
                fifo_pop_s  = 1'b1;
                fifo_push_s = resp_keep_s;
                insn_d      = fifo_head_s.data;
                insn_pc_d   = byte_addr(fifo_head_s.addr);
                insn_nop_d  = 1'b0;
            end else if (resp_keep_s) begin
                insn_d      = bus_data;
                insn_pc_d   = byte_addr(bus_addr_q);
                insn_nop_d  = 1'b0;
            end else begin
                insn_nop_d  = 1'b1;
            end
        end else begin
            fifo_push_s = resp_keep_s;
        end
    end

    // Issue decision: a request reserves a FIFO slot, so the next occupancy
    // must leave room. A flush issues the target directly when nothing stale
    // is still in flight, so the redirect costs no extra cycle.
    always_comb begin
        if (flush) begin
            count_next_s = {CW{1'b0}};
            issue_addr_s = target;
        end else begin
            count_next_s = fifo_count_s + CW'(fifo_push_s) - CW'(fifo_pop_s);
            issue_addr_s = fetch_pc_q;
        end
        issue_s = (!outstanding_q || resp_s) && (count_next_s < DEPTH_C);

        if (issue_s) begin
            fetch_pc_d = issue_addr_s + 30'd1;
            bus_addr_d = issue_addr_s;
        end else if (flush) begin
            fetch_pc_d = target;
            bus_addr_d = bus_addr_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
            bus_addr_d = bus_addr_q;
        end

        if (issue_s) begin
            outstanding_d = 1'b1;
        end else if (resp_s) begin
            outstanding_d = 1'b0;
        end else begin
            outstanding_d = outstanding_q;
        end

        // A flush only needs to drop a later response if one is still pending.
        if (flush) begin
            discard_d = outstanding_q && !bus_ready;
        end else if (resp_s) begin
            discard_d = 1'b0;
        end else begin
            discard_d = discard_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= 30'd0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            bus_start_q   <= 1'b0;
            bus_addr_q    <= 30'd0;
            insn_q        <= 32'd0;
            insn_pc_q     <= 32'd0;
            insn_nop_q    <= 1'b1;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            bus_start_q   <= issue_s;
            bus_addr_q    <= bus_addr_d;
            insn_q        <= insn_d;
            insn_pc_q     <= insn_pc_d;
            insn_nop_q    <= insn_nop_d;
        end
    end

    assign bus_start = bus_start_q;
    assign bus_addr  = bus_addr_q;
    assign insn      = insn_q;
    assign insn_pc   = insn_pc_q;
    assign insn_nop  = insn_nop_q;

endmodule

// File: tb/tb_core_prefetch_queue.sv
// Scoreboard bench for core_prefetch_queue: tests push the instructions they
// expect, a monitor pops and compares whenever decode receives a new one.
module tb_core_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [29:0] target;
    logic        bus_start;
    logic [29:0] bus_addr;
    logic        bus_ready;
    logic [31:0] bus_data;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_nop;

    // Bus responder (auto) plus a hand-driven strobe for directed corner cases.
    logic        auto_ready, man_ready;
    logic [31:0] auto_data, man_data;
    int          budget;
    int          lat;
    logic        pend_valid;
    int          pend_wait;
    logic [31:0] pend_data;

    assign bus_ready = auto_ready | man_ready;
    assign bus_data  = man_ready ? man_data : auto_data;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    logic loaded   = 1'b0;

    core_prefetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .target    (target),
        .bus_start (bus_start),
        .bus_addr  (bus_addr),
        .bus_ready (bus_ready),
        .bus_data  (bus_data),
        .insn      (insn),
        .insn_pc   (insn_pc),
        .insn_nop  (insn_nop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    function automatic void expect_insn(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        e.insn = i;
        e.pc   = pc;
        exp_q.push_back(e);
    endfunction

    // Memory returns 0xE3A00001 + word address after lat extra cycles.
    initial begin
        auto_ready = 1'b0;
        auto_data  = 32'd0;
        pend_valid = 1'b0;
        pend_wait  = 0;
        pend_data  = 32'd0;
        forever begin
            @(negedge clk);
            auto_ready = 1'b0;
            if (!rst_n) begin
                pend_valid = 1'b0;
            end else begin
                if (pend_valid) begin
                    if (pend_wait == 0) begin
                        auto_ready = 1'b1;
                        auto_data  = pend_data;
                        pend_valid = 1'b0;
                    end else begin
                        pend_wait--;
                    end
                end
                if (bus_start && budget > 0) begin
                    pend_valid = 1'b1;
                    pend_wait  = lat;
                    pend_data  = 32'hE3A0_0001 + {2'b00, bus_addr};
                    budget--;
                end
            end
        end
    end

    // An output is freshly loaded only after an edge without stall or flush.
    always @(posedge clk) loaded <= rst_n && !stall && !flush;

    // Monitor: every delivered instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && loaded && !insn_nop) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_insn: actual pc %h insn %h required no instruction", insn_pc, insn);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("insn", {32'd0, insn}, {32'd0, e.insn});
                check("insn_pc", {32'd0, insn_pc}, {32'd0, e.pc});
            end
        end
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        man_ready = 1'b0;
        man_data  = 32'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (6) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic wait_bus_start(input string name);
        int n = 0;
        while (!bus_start && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, "_seen"}, {63'd0, bus_start}, 64'd1);
    endtask

    initial begin
        int starts, valids;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; target = 30'd0;
        man_ready = 1'b0; man_data = 32'd0; budget = 0; lat = 0;

        // Reset values, then sequential fetch of three words.
        apply_reset();
        check("rst_insn", {32'd0, insn}, 64'd0);
        check("rst_insn_pc", {32'd0, insn_pc}, 64'd0);
        check("rst_insn_nop", {63'd0, insn_nop}, 64'd1);
        check("rst_bus_start", {63'd0, bus_start}, 64'd0);
        check("rst_bus_addr", {34'd0, bus_addr}, 64'd0);
        budget = 3;
        expect_insn(32'hE3A0_0001, 32'h0);
        expect_insn(32'hE3A0_0002, 32'h4);
        expect_insn(32'hE3A0_0003, 32'h8);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_bus_start", {63'd0, bus_start}, 64'd1);
        check("first_bus_addr", {34'd0, bus_addr}, 64'd0);
        drain("seq_drain");

        // Stall fills the FIFO to exactly DEPTH requests, then drains back to back.
        apply_reset();
        stall = 1'b1; budget = 4;
        rst_n = 1'b1;
        starts = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus_start) starts++;
        end
        check("stall_req_count", 64'(starts), 64'd4);
        expect_insn(32'hE3A0_0001, 32'h0);
        expect_insn(32'hE3A0_0002, 32'h4);
        expect_insn(32'hE3A0_0003, 32'h8);
        expect_insn(32'hE3A0_0004, 32'hC);
        stall = 1'b0;
        valids = 0;
        repeat (4) begin
            @(negedge clk);
            if (!insn_nop) valids++;
        end
        check("stall_drain_consecutive", 64'(valids), 64'd4);
        drain("stall_drain");

        // Flush with a request in flight: stale word dropped, refetch at target.
        apply_reset();
        lat = 3; budget = 3;
        expect_insn(32'hE3A0_0101, 32'h400);
        expect_insn(32'hE3A0_0102, 32'h404);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b1; target = 30'h100;
        @(negedge clk);
        flush = 1'b0;
        check("flush_nop", {63'd0, insn_nop}, 64'd1);
        wait_bus_start("flush_refetch");
        check("flush_refetch_addr", {34'd0, bus_addr}, 64'h100);
        drain("flush_drain");
        lat = 0;

        // Flush coincident with bus_ready under stall: buffered and arriving words gone.
        apply_reset();
        stall = 1'b1; budget = 2;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        budget = 1;
        man_ready = 1'b1; man_data = 32'h1234_5678;
        flush = 1'b1; target = 30'h200;
        @(negedge clk);
        man_ready = 1'b0; flush = 1'b0; stall = 1'b0;
        check("flush_rdy_nop", {63'd0, insn_nop}, 64'd1);
        check("flush_rdy_bus_start", {63'd0, bus_start}, 64'd1);
        check("flush_rdy_bus_addr", {34'd0, bus_addr}, 64'h200);
        expect_insn(32'hE3A0_0201, 32'h800);
        drain("flush_rdy_drain");

        // Fetch address wraps from 0x3FFFFFFF to 0.
        apply_reset();
        budget = 2;
        flush = 1'b1; target = 30'h3FFF_FFFF;
        expect_insn(32'h23A0_0000, 32'hFFFF_FFFC);
        expect_insn(32'hE3A0_0001, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("wrap_first_start", {63'd0, bus_start}, 64'd1);
        check("wrap_first_addr", {34'd0, bus_addr}, 64'h3FFF_FFFF);
        @(negedge clk);
        wait_bus_start("wrap_next");
        check("wrap_next_addr", {34'd0, bus_addr}, 64'd0);
        drain("wrap_drain");

        // Reset while a request is outstanding; a late bus_ready is ignored.
        apply_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        man_ready = 1'b1; man_data = 32'hDEAD_BEEF;
        budget = 1;
        expect_insn(32'hE3A0_0001, 32'h0);
        @(negedge clk);
        man_ready = 1'b0;
        check("late_rdy_bus_start", {63'd0, bus_start}, 64'd1);
        check("late_rdy_bus_addr", {34'd0, bus_addr}, 64'd0);
        check("late_rdy_nop", {63'd0, insn_nop}, 64'd1);
        drain("late_rdy_drain");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
